// File: rtl/ddr_rd_burst_engine.sv
// Splits one long read command into boundary-aligned AXI3 INCR bursts, keeps a bounded number in
// flight and streams returned beats straight to the consumer under its backpressure.
module ddr_rd_burst_engine #(
  parameter int         CTRL_ADDR_WIDTH = 28,
  parameter int         MEM_DQ_WIDTH    = 32,
  parameter int         ADDR_INC        = 8,
  parameter int         MAX_BURST       = 16,
  parameter int         BOUND_LOG2      = 5,
  parameter int         MAX_OUTST       = 4,
  parameter logic [3:0] AXI_ID          = 4'd0
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         rd_cmd_en,
  input  logic [CTRL_ADDR_WIDTH-1:0]   rd_cmd_addr,
  input  logic [31:0]                  rd_cmd_len,
  output logic                         rd_cmd_ready,
  output logic                         rd_cmd_done,
  output logic                         rd_cmd_err,
  input  logic                         read_ready,
  output logic [MEM_DQ_WIDTH*8-1:0]    read_rdata,
  output logic                         read_en,
  output logic [CTRL_ADDR_WIDTH-1:0]   axi_araddr,
  output logic [3:0]                   axi_arid,
  output logic [3:0]                   axi_arlen,
  output logic [2:0]                   axi_arsize,
  output logic [1:0]                   axi_arburst,
  output logic                         axi_arvalid,
  input  logic                         axi_arready,
  output logic                         axi_rready,
  input  logic [MEM_DQ_WIDTH*8-1:0]    axi_rdata,
  input  logic                         axi_rvalid,
  input  logic                         axi_rlast,
  input  logic [3:0]                   axi_rid,
  input  logic [1:0]                   axi_rresp
);

  localparam int         CAW       = CTRL_ADDR_WIDTH;
  localparam int         INC_LOG2  = $clog2(ADDR_INC);
  localparam int         PTR_W     = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam logic [3:0] OUTST_MAX = 4'(MAX_OUTST);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t                state;
  logic [CAW-1:0]        cur_addr;
  logic [31:0]           rem_issue;
  logic [31:0]           rem_recv;
  logic [3:0]            outst;
  logic                  err_q;
  logic [4:0]            beat_cnt;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [3:0]            arlen_fifo [MAX_OUTST];
  logic [4:0]            burst;
  logic                  ar_hs;
  logic                  r_last_hs;
  logic                  beat_bad;
  logic                  unused_rid;

  // Beats for the next burst: limited by what is left, the burst cap and the aligned boundary.
  function automatic logic [4:0] calc_burst(input logic [CAW-1:0] addr, input logic [31:0] rem);
    logic [CAW-1:0] beat_idx;
    logic [32:0]    room;
    logic [32:0]    lim;
    beat_idx = addr >> INC_LOG2;
    room     = 33'd1 << BOUND_LOG2;
    room     = room - (33'(beat_idx) & (room - 33'd1));
    lim      = 33'(MAX_BURST);
    if (room < lim) lim = room;
    if ({1'b0, rem} < lim) lim = {1'b0, rem};
    return 5'(lim);
  endfunction

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTST - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign axi_arid    = AXI_ID;
  assign axi_arsize  = 3'($clog2(MEM_DQ_WIDTH));
  assign axi_arburst = 2'b01;
  assign axi_rready  = read_ready & (state != S_IDLE);
  assign read_en     = axi_rvalid & axi_rready;
  assign read_rdata  = axi_rdata;
  assign burst       = calc_burst(cur_addr, rem_issue);
  assign ar_hs       = axi_arvalid & axi_arready;
  assign r_last_hs   = read_en & axi_rlast;
  assign unused_rid  = ^axi_rid;

  // A beat is bad on an error response or when rlast disagrees with the recorded burst length.
  assign beat_bad = (axi_rresp != 2'b00) || (outst == 4'd0) ||
                    (axi_rlast != (beat_cnt == {1'b0, arlen_fifo[rd_ptr]}));

  always_ff @(posedge clk) begin
    if (ar_hs) arlen_fifo[wr_ptr] <= axi_arlen;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state        <= S_IDLE;
      rd_cmd_ready <= 1'b1;
      rd_cmd_done  <= 1'b0;
      rd_cmd_err   <= 1'b0;
      axi_arvalid  <= 1'b0;
      axi_araddr   <= '0;
      axi_arlen    <= '0;
      cur_addr     <= '0;
      rem_issue    <= '0;
      rem_recv     <= '0;
      outst        <= '0;
      err_q        <= 1'b0;
      beat_cnt     <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
    end else begin
      rd_cmd_done <= 1'b0;
      rd_cmd_err  <= 1'b0;

      if (read_en) begin
        if (rem_recv != 32'd0) rem_recv <= rem_recv - 32'd1;
        if (beat_bad) err_q <= 1'b1;
        if (axi_rlast) begin
          beat_cnt <= '0;
          if (outst != 4'd0) rd_ptr <= ptr_next(rd_ptr);
        end else begin
          beat_cnt <= beat_cnt + 5'd1;
        end
      end

      if (ar_hs) wr_ptr <= ptr_next(wr_ptr);
      if (ar_hs && !r_last_hs) outst <= outst + 4'd1;
      else if (!ar_hs && r_last_hs && outst != 4'd0) outst <= outst - 4'd1;

      unique case (state)
        S_IDLE: begin
          if (rd_cmd_en) begin
            rd_cmd_ready <= 1'b0;
            cur_addr     <= rd_cmd_addr;
            rem_issue    <= rd_cmd_len;
            rem_recv     <= rd_cmd_len;
            err_q        <= 1'b0;
            beat_cnt     <= '0;
            state        <= (rd_cmd_len == 32'd0) ? S_DRAIN : S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (axi_arvalid) begin
            if (axi_arready) begin
              axi_arvalid <= 1'b0;
              cur_addr    <= cur_addr + (CAW'({1'b0, axi_arlen} + 5'd1) << INC_LOG2);
              rem_issue   <= rem_issue - 32'({1'b0, axi_arlen}) - 32'd1;
              if (rem_issue == 32'({1'b0, axi_arlen}) + 32'd1) state <= S_DRAIN;
            end
          end else if (outst < OUTST_MAX) begin
            axi_arvalid <= 1'b1;
            axi_araddr  <= cur_addr;
            axi_arlen   <= 4'(burst - 5'd1);
          end
        end
        S_DRAIN: begin
          // Finish on the edge that takes the final beat so done trails it by one cycle.
          if (rem_recv == 32'd0 || (read_en && rem_recv == 32'd1)) begin
            state       <= S_DONE;
            rd_cmd_done <= 1'b1;
            rd_cmd_err  <= err_q | (read_en & beat_bad);
          end
        end
        S_DONE: begin
          state        <= S_IDLE;
          rd_cmd_ready <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_rd_burst_engine.sv
// Randomised bench for ddr_rd_burst_engine: an AXI read slave, a burst-splitting reference model
// and a scoreboard monitor that checks AR requests, beat data order and command completion.
module tb_ddr_rd_burst_engine;

  localparam int CAW  = 28;
  localparam int DW   = 256;
  localparam int AINC = 8;
  localparam int MAXB = 16;
  localparam int BL2  = 5;
  localparam int MAXO = 4;

  typedef struct { logic [27:0] addr; logic [3:0] arlen; } exp_ar_t;
  typedef struct { bit err; int lat; } exp_done_t;
  typedef struct { logic [27:0] addr; int len; } sl_burst_t;

  logic           clk = 1'b0;
  logic           rstn = 1'b0;
  logic           rd_cmd_en = 1'b0;
  logic [27:0]    rd_cmd_addr = '0;
  logic [31:0]    rd_cmd_len = '0;
  logic           rd_cmd_ready, rd_cmd_done, rd_cmd_err;
  logic           read_ready = 1'b1;
  logic [DW-1:0]  read_rdata;
  logic           read_en;
  logic [27:0]    axi_araddr;
  logic [3:0]     axi_arid, axi_arlen;
  logic [2:0]     axi_arsize;
  logic [1:0]     axi_arburst;
  logic           axi_arvalid;
  logic           axi_arready = 1'b0;
  logic           axi_rready;
  logic [DW-1:0]  axi_rdata = '0;
  logic           axi_rvalid = 1'b0;
  logic           axi_rlast = 1'b0;
  logic [3:0]     axi_rid = 4'd0;
  logic [1:0]     axi_rresp = 2'b00;

  ddr_rd_burst_engine dut (
    .clk(clk), .rstn(rstn),
    .rd_cmd_en(rd_cmd_en), .rd_cmd_addr(rd_cmd_addr), .rd_cmd_len(rd_cmd_len),
    .rd_cmd_ready(rd_cmd_ready), .rd_cmd_done(rd_cmd_done), .rd_cmd_err(rd_cmd_err),
    .read_ready(read_ready), .read_rdata(read_rdata), .read_en(read_en),
    .axi_araddr(axi_araddr), .axi_arid(axi_arid), .axi_arlen(axi_arlen),
    .axi_arsize(axi_arsize), .axi_arburst(axi_arburst), .axi_arvalid(axi_arvalid),
    .axi_arready(axi_arready), .axi_rready(axi_rready), .axi_rdata(axi_rdata),
    .axi_rvalid(axi_rvalid), .axi_rlast(axi_rlast), .axi_rid(axi_rid), .axi_rresp(axi_rresp)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  exp_ar_t     exp_ar_q[$];
  logic [DW-1:0] exp_data_q[$];
  exp_done_t   exp_done_q[$];
  sl_burst_t   sl_q[$];
  int sl_idx = 0;
  int glob_beat = 0;
  int inj_idx = -1;
  int out_cnt = 0;
  int ar_total = 0;
  int done_cnt = 0;
  int cyc = 0;
  int last_evt = 0;
  bit busy_tb = 0;
  bit prev_done = 0;
  bit prev_stall = 0;
  bit last_r_fire = 0;
  bit hold_r = 0;
  int rr_mode = 2;
  int arready_pct = 100;
  logic [27:0] prev_araddr = '0;
  logic [3:0]  prev_arlen = '0;

  function automatic logic [DW-1:0] beat_data(input logic [27:0] a);
    return {8{{4'hA, a}}};
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: split the command using plain arithmetic on beat indices.
  task automatic model_cmd(input logic [27:0] a, input int len, input int inj);
    longint cur, rem, beat, room, b;
    cur = longint'(a);
    rem = len;
    while (rem > 0) begin
      beat = cur / AINC;
      room = (longint'(1) << BL2) - (beat % (longint'(1) << BL2));
      b = rem;
      if (b > MAXB) b = MAXB;
      if (b > room) b = room;
      exp_ar_q.push_back('{addr: 28'(cur), arlen: 4'(b - 1)});
      cur = (cur + b * AINC) % (longint'(1) << CAW);
      rem = rem - b;
    end
    for (int i = 0; i < len; i++)
      exp_data_q.push_back(beat_data(28'((longint'(a) + longint'(i) * AINC) % (longint'(1) << CAW))));
    exp_done_q.push_back('{err: (inj >= 0 && inj < len), lat: (len == 0) ? 2 : 1});
  endtask

  // Monitor and slave bookkeeping, sampled mid-cycle where everything is stable.
  always @(negedge clk) begin
    bit ar_fire, r_fire;
    cyc++;
    if (!rstn) begin
      sl_q.delete();
      sl_idx = 0;
      out_cnt = 0;
      prev_stall = 0;
      prev_done = 0;
      last_r_fire = 0;
    end else begin
      ar_fire = axi_arvalid && axi_arready;
      r_fire  = read_en;
      if (prev_done) chk("ready_after_done", rd_cmd_ready, 1);
      chk("rready_follow", axi_rready, read_ready & busy_tb);
      if (prev_stall) begin
        chk("arvalid_hold", axi_arvalid, 1);
        chk("araddr_hold", axi_araddr, prev_araddr);
        chk("arlen_hold", axi_arlen, prev_arlen);
      end
      if (rd_cmd_en && rd_cmd_ready) begin
        glob_beat = 0;
        last_evt = cyc;
      end
      if (ar_fire) begin
        chk("outstanding_limit", (out_cnt < MAXO), 1);
        chk("arid", axi_arid, 0);
        chk("arsize", axi_arsize, 5);
        chk("arburst", axi_arburst, 1);
        if (exp_ar_q.size() == 0) begin
          chk("unexpected_ar", 1, 0);
        end else begin
          exp_ar_t e;
          e = exp_ar_q.pop_front();
          chk("araddr", axi_araddr, e.addr);
          chk("arlen", axi_arlen, e.arlen);
        end
        sl_q.push_back('{addr: axi_araddr, len: int'(axi_arlen) + 1});
        out_cnt++;
        ar_total++;
      end
      if (r_fire) begin
        if (exp_data_q.size() == 0) begin
          chk("unexpected_beat", 1, 0);
        end else begin
          logic [DW-1:0] ed;
          ed = exp_data_q.pop_front();
          checks++;
          if (read_rdata !== ed) begin
            errors++;
            $display("FAIL rdata: got %h, expected %h", read_rdata, ed);
          end
        end
        last_evt = cyc;
        glob_beat++;
        if (axi_rlast) out_cnt--;
        if (sl_q.size() > 0) begin
          sl_idx++;
          if (sl_idx >= sl_q[0].len) begin
            void'(sl_q.pop_front());
            sl_idx = 0;
          end
        end
      end
      if (rd_cmd_done) begin
        if (exp_done_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_done_t d;
          d = exp_done_q.pop_front();
          chk("done_err", rd_cmd_err, d.err);
          chk("done_latency", cyc - last_evt, d.lat);
          chk("done_ar_drained", exp_ar_q.size(), 0);
          chk("done_data_drained", exp_data_q.size(), 0);
        end
        busy_tb = 0;
        done_cnt++;
      end
      if (rd_cmd_en && rd_cmd_ready) busy_tb = 1;
      prev_done   = rd_cmd_done;
      prev_stall  = axi_arvalid && !axi_arready;
      prev_araddr = axi_araddr;
      prev_arlen  = axi_arlen;
      last_r_fire = r_fire;
    end
  end

  // Slave and consumer drive, just after each active edge.
  always @(posedge clk) begin
    #1;
    axi_arready = ($urandom_range(0, 99) < arready_pct);
    case (rr_mode)
      0:       read_ready = ($urandom_range(0, 3) != 0);
      1:       read_ready = !read_ready;
      default: read_ready = 1'b1;
    endcase
    if (!(axi_rvalid && !last_r_fire && sl_q.size() > 0)) begin
      if (hold_r || sl_q.size() == 0) axi_rvalid = 1'b0;
      else axi_rvalid = ($urandom_range(0, 3) != 0);
    end
    if (sl_q.size() > 0) begin
      axi_rdata = beat_data(sl_q[0].addr + 28'(sl_idx * AINC));
      axi_rlast = (sl_idx == sl_q[0].len - 1);
      axi_rresp = (glob_beat == inj_idx) ? 2'b10 : 2'b00;
    end else begin
      axi_rlast = 1'b0;
      axi_rresp = 2'b00;
    end
  end

  task automatic flush_model();
    exp_ar_q.delete();
    exp_data_q.delete();
    exp_done_q.delete();
    busy_tb = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rstn = 1'b0;
    rd_cmd_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    flush_model();
    @(posedge clk); #1;
    rstn = 1'b1;
  endtask

  task automatic issue(input logic [27:0] a, input int len, input int inj, input bit extra);
    int t;
    t = 0;
    @(negedge clk);
    while (!rd_cmd_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("cmd_ready_wait", rd_cmd_ready, 1);
    model_cmd(a, len, inj);
    inj_idx = inj;
    ar_total = 0;
    @(posedge clk); #1;
    rd_cmd_en = 1'b1;
    rd_cmd_addr = a;
    rd_cmd_len = 32'(len);
    @(posedge clk); #1;
    if (extra) begin
      rd_cmd_addr = 28'h0000100;
      rd_cmd_len = 32'd5;
      repeat (2) @(posedge clk);
      #1;
    end
    rd_cmd_en = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    int t;
    t = 0;
    while (done_cnt <= d0 && t < 4000) begin
      @(negedge clk);
      t++;
    end
    if (done_cnt <= d0) begin
      chk("done_timeout", 0, 1);
      do_reset();
    end
  endtask

  task automatic run_cmd(input logic [27:0] a, input int len, input int inj, input bit extra);
    int d0;
    d0 = done_cnt;
    issue(a, len, inj, extra);
    wait_done(d0);
  endtask

  initial begin
    int d0, t, len, inj;
    logic [27:0] a;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", rd_cmd_ready, 1);
    chk("rst_done", rd_cmd_done, 0);
    chk("rst_err", rd_cmd_err, 0);
    chk("rst_arvalid", axi_arvalid, 0);
    chk("rst_araddr", axi_araddr, 0);
    chk("rst_arlen", axi_arlen, 0);
    chk("rst_rready", axi_rready, 0);
    @(posedge clk); #1;
    rstn = 1'b1;

    rr_mode = 2; arready_pct = 100;
    run_cmd(28'd0, 40, -1, 1'b1);
    run_cmd(28'd224, 10, -1, 1'b0);

    hold_r = 1;
    d0 = done_cnt;
    issue(28'd0, 96, -1, 1'b0);
    repeat (60) @(negedge clk);
    chk("hold_ar_count", ar_total, MAXO);
    chk("hold_arvalid", axi_arvalid, 0);
    hold_r = 0;
    wait_done(d0);

    rr_mode = 1;
    run_cmd(28'd512, 16, -1, 1'b0);
    rr_mode = 2;
    run_cmd(28'd64, 0, -1, 1'b0);
    run_cmd(28'd0, 8, 3, 1'b0);
    run_cmd(28'd40, 12, -1, 1'b0);
    run_cmd(28'hFFFFFE8, 10, -1, 1'b0);

    rr_mode = 2; arready_pct = 70;
    issue(28'd0, 64, -1, 1'b0);
    t = 0;
    while (glob_beat < 5 && t < 500) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk); #1;
    rstn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_ready", rd_cmd_ready, 1);
    chk("midrst_done", rd_cmd_done, 0);
    chk("midrst_err", rd_cmd_err, 0);
    chk("midrst_arvalid", axi_arvalid, 0);
    chk("midrst_araddr", axi_araddr, 0);
    chk("midrst_arlen", axi_arlen, 0);
    chk("midrst_rready", axi_rready, 0);
    flush_model();
    @(posedge clk); #1;
    rstn = 1'b1;
    run_cmd(28'd1000, 20, -1, 1'b0);

    for (int k = 0; k < 25; k++) begin
      a = 28'(longint'($urandom_range(0, 33554431)) * AINC);
      len = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 70));
      inj = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len)) : -1;
      rr_mode = int'($urandom_range(0, 2));
      arready_pct = int'($urandom_range(30, 100));
      run_cmd(a, len, inj, 1'b0);
    end

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
